// File: rtl/log_fpmul_stream.sv
`default_nettype none
// ============================================================================
// Module      : log_fpmul_stream
// Description : Byte-serial floating-point multiplier with run-time choice of
//               Mitchell log-domain approximation or exact truncated product.
// Revision    : 1.0 - initial release
// ============================================================================
module log_fpmul_stream #(
    parameter int EW = 5,
    parameter int MW = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    input  logic       mode,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic [2:0] flags
);

    localparam int W     = 1 + EW + MW;
    localparam int NB    = (W + 7) / 8;
    localparam int NBITS = NB * 8;
    localparam int BIAS  = (1 << (EW - 1)) - 1;
    localparam int IW    = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
    localparam logic [EW+1:0] C_BIAS   = (EW+2)'(BIAS);
    localparam logic [EW+1:0] C_EMAX   = (EW+2)'((1 << EW) - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_SEND    = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [IW-1:0]    idx_q;
    logic             live_q;
    logic             mode_q;
    logic [NBITS-1:0] a_q;
    logic [NBITS-1:0] b_q;
    logic [NBITS-1:0] res_q;
    logic [2:0]       flags_q;

    logic             w_accept;
    logic             w_xfer;
    logic             w_idx_last;

    logic             w_sign;
    logic [EW-1:0]    w_ea;
    logic [EW-1:0]    w_eb;
    logic [MW-1:0]    w_ma;
    logic [MW-1:0]    w_mb;
    logic [MW:0]      w_sum;
    logic [2*MW+1:0]  w_prod;
    logic             w_carry;
    logic [MW-1:0]    w_mout;
    logic [EW+1:0]    w_exp;
    logic             w_zero_in;
    logic             w_sat_in;
    logic             w_ovf_e;
    logic             w_unf_e;
    logic [W-1:0]     w_res;
    logic [NBITS-1:0] w_res_ext;
    logic [2:0]       w_flags;
    logic             w_unused;

    assign w_accept   = in_valid & in_ready;
    assign w_xfer     = out_valid & out_ready;
    assign w_idx_last = (idx_q == LAST_IDX);

    // ------------------------------------------------------------------
    // Arithmetic core: operates on the fully collected operand words
    // ------------------------------------------------------------------
    assign w_sign = a_q[W-1] ^ b_q[W-1];
    assign w_ea   = a_q[W-2:MW];
    assign w_eb   = b_q[W-2:MW];
    assign w_ma   = a_q[MW-1:0];
    assign w_mb   = b_q[MW-1:0];

    assign w_sum  = {1'b0, w_ma} + {1'b0, w_mb};
    assign w_prod = {{(MW+1){1'b0}}, 1'b1, w_ma} * {{(MW+1){1'b0}}, 1'b1, w_mb};

    always_comb begin
        w_carry = 1'b0;
        w_mout  = '0;
        if (mode_q) begin
            w_carry = w_prod[2*MW+1];
            w_mout  = w_carry ? w_prod[2*MW:MW+1] : w_prod[2*MW-1:MW];
        end else begin
            w_carry = w_sum[MW];
            w_mout  = w_sum[MW-1:0];
        end
    end

    // Signed exponent in EW+2 bits: the MSB is the sign after bias removal
    assign w_exp     = {2'b00, w_ea} + {2'b00, w_eb} - C_BIAS + {{(EW+1){1'b0}}, w_carry};
    assign w_zero_in = ~(|w_ea) | ~(|w_eb);
    assign w_sat_in  = (&w_ea) | (&w_eb);
    assign w_ovf_e   = ~w_exp[EW+1] & (w_exp >= C_EMAX);
    assign w_unf_e   = w_exp[EW+1] | (w_exp == '0);

    always_comb begin
        w_res      = '0;
        w_flags    = 3'b000;
        w_res[W-1] = w_sign;
        if (w_zero_in) begin
            w_flags = 3'b001;
        end else if (w_sat_in | w_ovf_e) begin
            w_res[W-2:MW] = '1;
            w_flags       = 3'b100;
        end else if (w_unf_e) begin
            w_flags = 3'b010;
        end else begin
            w_res[W-2:MW] = w_exp[EW-1:0];
            w_res[MW-1:0] = w_mout;
        end
    end

    always_comb begin
        w_res_ext        = '0;
        w_res_ext[W-1:0] = w_res;
    end

    assign w_unused = ^{a_q, b_q, w_prod[MW-1:0]};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (w_accept && w_idx_last) state_d = S_COMPUTE;
            S_COMPUTE: state_d = S_SEND;
            S_SEND:    if (w_xfer && w_idx_last) state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_byte  = '0;
        flags     = flags_q;
        case (state_q)
            S_COLLECT: in_ready = live_q;
            S_SEND: begin
                out_valid = 1'b1;
                out_last  = w_idx_last;
                for (int k = 0; k < NB; k++) begin
                    if (idx_q == IW'(k)) out_byte = res_q[k*8 +: 8];
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers; live_q keeps in_ready low while reset is held
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q  <= 1'b0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= 3'b000;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                S_COLLECT: begin
                    if (w_accept) begin
                        for (int k = 0; k < NB; k++) begin
                            if (idx_q == IW'(k)) begin
                                a_q[k*8 +: 8] <= a_byte;
                                b_q[k*8 +: 8] <= b_byte;
                            end
                        end
                        if (idx_q == '0) mode_q <= mode;
                        idx_q <= w_idx_last ? '0 : idx_q + IW'(1);
                    end
                end
                S_COMPUTE: begin
                    res_q   <= w_res_ext;
                    flags_q <= w_flags;
                    idx_q   <= '0;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (w_idx_last) begin
                            idx_q   <= '0;
                            flags_q <= 3'b000;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_log_fpmul_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_log_fpmul_stream
// Description : Scoreboard bench for FP16 and BF16 instances of the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_log_fpmul_stream;

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  fl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, mode, out_valid, out_ready, out_last;
    logic [7:0] a_byte, b_byte, out_byte;
    logic [2:0] flags;

    logic       in_valid2, in_ready2, mode2, out_valid2, out_ready2, out_last2;
    logic [7:0] a_byte2, b_byte2, out_byte2;
    logic [2:0] flags2;

    int   checks = 0;
    int   errors = 0;
    int   stall  = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    log_fpmul_stream #(.EW(5), .MW(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_byte(a_byte), .b_byte(b_byte), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last), .flags(flags)
    );

    log_fpmul_stream #(.EW(8), .MW(7)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_byte(a_byte2), .b_byte(b_byte2), .mode(mode2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_byte(out_byte2), .out_last(out_last2), .flags(flags2)
    );

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: value-level arithmetic on sign / exponent / mantissa fields
    function automatic void fp_ref(input int ew, input int mw, input longint a, input longint b,
                                   input bit md, output longint res, output logic [2:0] fl);
        longint mone, emax, bias, sa, sb, ea, eb, ma, mb, sign, c, mo, e, p, s;
        mone = longint'(1) << mw;
        emax = (longint'(1) << ew) - 1;
        bias = (longint'(1) << (ew - 1)) - 1;
        sa = (a >> (ew + mw)) & 1;
        sb = (b >> (ew + mw)) & 1;
        ea = (a >> mw) & emax;
        eb = (b >> mw) & emax;
        ma = a & (mone - 1);
        mb = b & (mone - 1);
        sign = (sa ^ sb) << (ew + mw);
        if (md == 1'b0) begin
            s  = ma + mb;
            c  = (s >= mone) ? 1 : 0;
            mo = s - c * mone;
        end else begin
            p = (mone + ma) * (mone + mb);
            if (p >= (longint'(1) << (2 * mw + 1))) begin
                c  = 1;
                mo = (p >> (mw + 1)) - mone;
            end else begin
                c  = 0;
                mo = (p >> mw) - mone;
            end
        end
        e = ea + eb - bias + c;
        if (ea == 0 || eb == 0) begin
            res = sign; fl = 3'b001;
        end else if (ea == emax || eb == emax || e >= emax) begin
            res = sign | (emax << mw); fl = 3'b100;
        end else if (e <= 0) begin
            res = sign; fl = 3'b010;
        end else begin
            res = sign | (e << mw) | mo; fl = 3'b000;
        end
    endfunction

    // ---------------- FP16 monitor ----------------
    int         j1 = 0;
    logic       hold1 = 1'b0;
    logic [7:0] hb;
    logic       hl;
    logic [2:0] hf;
    exp_t       e1;
    logic [15:0] sh1;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_byte", out_byte, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_flags", flags, 0);
            q1.delete();
            j1 = 0; hold1 = 1'b0; stall = 0; out_ready = 1'b0;
        end else begin
            if (hold1) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_byte", out_byte, hb);
                chk("hold_last", out_last, hl);
                chk("hold_flags", flags, hf);
            end
            if (out_valid) begin
                if (in_ready) chk("overlap_in_ready", in_ready, 0);
                if (q1.size() == 0) begin
                    chk("unexpected_output", out_valid, 0);
                end else begin
                    e1  = q1[0];
                    sh1 = e1.res >> (8 * j1);
                    chk("out_byte", out_byte, sh1[7:0]);
                    chk("out_last", out_last, (j1 == 1) ? 1 : 0);
                    chk("flags", flags, e1.fl);
                end
                if (stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else begin
                    out_ready = ($urandom % 4) != 0;
                end
                hold1 = !out_ready;
                hb = out_byte; hl = out_last; hf = flags;
                if (out_ready && q1.size() != 0) begin
                    if (j1 == 1) begin
                        void'(q1.pop_front());
                        j1 = 0;
                    end else begin
                        j1++;
                    end
                end
            end else begin
                chk("idle_flags", flags, 0);
                chk("idle_out_last", out_last, 0);
                hold1 = 1'b0;
                out_ready = $urandom % 2;
            end
        end
    end

    // ---------------- BF16 monitor ----------------
    int          j2 = 0;
    exp_t        e2;
    logic [15:0] sh2;

    always @(negedge clk) begin
        if (!rst_n) begin
            q2.delete();
            j2 = 0; out_ready2 = 1'b0;
        end else if (out_valid2) begin
            if (q2.size() == 0) begin
                chk("bf16_unexpected_output", out_valid2, 0);
            end else begin
                e2  = q2[0];
                sh2 = e2.res >> (8 * j2);
                chk("bf16_out_byte", out_byte2, sh2[7:0]);
                chk("bf16_out_last", out_last2, (j2 == 1) ? 1 : 0);
                chk("bf16_flags", flags2, e2.fl);
            end
            out_ready2 = $urandom % 2;
            if (out_ready2 && q2.size() != 0) begin
                if (j2 == 1) begin
                    void'(q2.pop_front());
                    j2 = 0;
                end else begin
                    j2++;
                end
            end
        end else begin
            out_ready2 = $urandom % 2;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input bit md,
                           input int gap, input int st);
        longint      r;
        logic [2:0]  f;
        exp_t        e;
        logic [15:0] av, bv;
        int          t;
        fp_ref(5, 10, {48'd0, a}, {48'd0, b}, md, r, f);
        e.res = r[15:0];
        e.fl  = f;
        q1.push_back(e);
        for (int k = 0; k < 2; k++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                if (!in_ready) begin
                    in_valid = 1'b1; a_byte = 8'($urandom); b_byte = 8'($urandom); mode = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            av = a >> (8 * k);
            bv = b >> (8 * k);
            in_valid = 1'b1;
            a_byte   = av[7:0];
            b_byte   = bv[7:0];
            mode     = (k == 0) ? md : !md;
            t = 0;
            while (!in_ready && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 1000) chk("in_ready_timeout", 0, 1);
            @(posedge clk);
            stall = (k == 1) ? st : stall;
            #1 in_valid = 1'b0;
        end
        @(negedge clk);
        chk("compute_out_valid", out_valid, 0);
        chk("compute_in_ready", in_ready, 0);
        @(negedge clk);
        chk("latency_out_valid", out_valid, 1);
    endtask

    task automatic send_op2(input logic [15:0] a, input logic [15:0] b, input bit md);
        longint      r;
        logic [2:0]  f;
        exp_t        e;
        logic [15:0] av, bv;
        int          t;
        fp_ref(8, 7, {48'd0, a}, {48'd0, b}, md, r, f);
        e.res = r[15:0];
        e.fl  = f;
        q2.push_back(e);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            av = a >> (8 * k);
            bv = b >> (8 * k);
            in_valid2 = 1'b1;
            a_byte2   = av[7:0];
            b_byte2   = bv[7:0];
            mode2     = (k == 0) ? md : !md;
            t = 0;
            while (!in_ready2 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 1000) chk("bf16_in_ready_timeout", 0, 1);
            @(posedge clk);
            #1 in_valid2 = 1'b0;
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        int          t;
        rst_n = 1'b0;
        in_valid = 1'b0; a_byte = '0; b_byte = '0; mode = 1'b0;
        in_valid2 = 1'b0; a_byte2 = '0; b_byte2 = '0; mode2 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_release", in_ready, 1);

        send_op(16'h3E00, 16'h3E00, 1'b1, 0, 0);
        send_op(16'h3E00, 16'h3E00, 1'b0, 0, 0);
        send_op(16'hC000, 16'h4200, 1'b0, 1, 0);
        send_op(16'h7800, 16'h7800, 1'b1, 0, 0);
        send_op(16'h0400, 16'h0400, 1'b0, 0, 0);
        send_op(16'h8000, 16'h3C00, 1'b1, 0, 0);
        send_op(16'h3E00, 16'h3E00, 1'b1, 2, 5);
        send_op(16'h3E00, 16'h3E00, 1'b0, 3, 0);
        send_op(16'hFC00, 16'h3C00, 1'b1, 0, 0);

        // Abort in the middle of a result packet
        send_op(16'h3E00, 16'h3E00, 1'b1, 0, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_byte", out_byte, 0);
        chk("abort_flags", flags, 0);
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_abort", in_ready, 1);
        send_op(16'hC000, 16'h4200, 1'b0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom % 8)
                0: ra[14:10] = 5'd0;
                1: rb[14:10] = 5'h1F;
                2: begin ra[14:10] = 5'(4 + $urandom % 8); rb[14:10] = 5'(4 + $urandom % 8); end
                3: begin ra[14:10] = 5'(20 + $urandom % 8); rb[14:10] = 5'(20 + $urandom % 8); end
                default: ;
            endcase
            send_op(ra, rb, 1'($urandom), $urandom_range(0, 2), (($urandom % 5) == 0) ? $urandom_range(1, 4) : 0);
        end

        send_op2(16'h3FC0, 16'h3FC0, 1'b1);
        send_op2(16'h3FC0, 16'h3FC0, 1'b0);
        send_op2(16'h0080, 16'h0080, 1'b1);
        send_op2(16'h7F00, 16'h4000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send_op2(16'($urandom), 16'($urandom), 1'($urandom));
        end

        t = 0;
        while ((q1.size() != 0 || q2.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("queues_drained", q1.size() + q2.size(), 0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
